// File: rtl/interrupt_scheduler_pkg.sv
// Shared definitions for the PCIe interrupt scheduler: FSM state encoding and
// parameter limits/defaults used by the scheduler and its round-robin picker.
package interrupt_scheduler_pkg;

   localparam int unsigned NREQ_MAX        = 8;
   localparam int unsigned HOLDOFF_DEFAULT = 1024;

   // One-hot encoding shared with the rest of the endpoint logic.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_ASSERT  = 3'b010,
      ST_HOLDOFF = 3'b100
   } state_e;

endpackage

// File: rtl/interrupt_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or above
// ptr, wrapping modulo NREQ.
module int_rr_pick
   import interrupt_scheduler_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      int unsigned cand;
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = (32'(ptr) + i) % NREQ;
         if (!valid && req[cand[PTR_W-1:0]]) begin
            valid = 1'b1;
            idx   = cand[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/interrupt_scheduler.sv
// Shares the PCIe core interrupt port among NREQ requesters: round-robin grant,
// core handshake, global enable gating and a moderation holdoff between interrupts.
module interrupt_scheduler
   import interrupt_scheduler_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_DEFAULT,
   parameter int unsigned HOLDOFF_W      = 16
) (
   input  logic            trn_clk,
   input  logic            reset,
   input  logic            interrupts_enabled,
   input  logic [NREQ-1:0] int_req,
   output logic [NREQ-1:0] int_ack,
   output logic            cfg_interrupt_n,
   input  logic            cfg_interrupt_rdy_n,
   output logic [7:0]      cfg_interrupt_di,
   output logic            busy
);

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       idx_q, idx_d;
   logic [HOLDOFF_W-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]        ack_q, ack_d;
   logic                   cfg_n_q, cfg_n_d;
   logic [7:0]             di_q, di_d;

   logic                   pick_valid;
   logic [PTR_W-1:0]       pick_idx;

   int_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (int_req),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      ack_d    = '0;
      cfg_n_d  = cfg_n_q;
      di_d     = di_q;
      case (state_q)
         ST_IDLE: begin
            if (interrupts_enabled && pick_valid) begin
               state_d = ST_ASSERT;
               idx_d   = pick_idx;
               di_d    = 8'(pick_idx);
               cfg_n_d = 1'b0;
            end
         end
         // Enable and request are deliberately ignored here: the core handshake must finish.
         ST_ASSERT: begin
            if (!cfg_interrupt_rdy_n) begin
               state_d       = ST_HOLDOFF;
               cfg_n_d       = 1'b1;
               ack_d[idx_q]  = 1'b1;
               rr_ptr_d      = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
               cnt_d         = HOLDOFF_W'(HOLDOFF_CYCLES);
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cfg_n_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         ack_q    <= '0;
         cfg_n_q  <= 1'b1;
         di_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         cfg_n_q  <= cfg_n_d;
         di_q     <= di_d;
      end
   end

   assign int_ack          = ack_q;
   assign cfg_interrupt_n  = cfg_n_q;
   assign cfg_interrupt_di = di_q;
   assign busy             = (state_q != ST_IDLE);

endmodule
